bin_to_seg: RTL and testbench



---
 rtl/seg_pkg.sv | 65 ++++++
 rtl/seg7_enc.sv | 15 +
 rtl/bin_to_seg.sv | 147 ++++++++++++++
 tb/tb_bin_to_seg.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the binary-to-7-segment display formatter.
// Holds the FSM state encoding, the hex glyph table, the blank glyph, the
// digit count and the per-nibble BCD add-3 correction used by double-dabble.
package seg_pkg;

    // Number of display digits driven by the formatter
    localparam int SEG_DIGITS = 8;

    // Width of the BCD / hex accumulator (eight nibbles)
    localparam int SEG_ACC_W = 4 * SEG_DIGITS;

    // Glyph byte for a dark digit (no segments, no decimal point)
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Formatter FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } seg_state_t;

    // Segment patterns, bit0 = a ... bit6 = g, indexed by nibble value 0..F
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    // Double-dabble correction for one BCD nibble: values of 5 or more get +3
    // so that the following left shift carries correctly into the next digit.
    // The add stays within the nibble; no carry leaves it.
    function automatic logic [3:0] bcd_add3(input logic [3:0] i_nib);
        logic [3:0] v_res;
        if (i_nib >= 4'd5) begin
            v_res = i_nib + 4'd3;
        end else begin
            v_res = i_nib;
        end
        return v_res;
    endfunction

    // Applies the add-3 correction independently to every accumulator nibble
    function automatic logic [SEG_ACC_W-1:0] bcd_correct(input logic [SEG_ACC_W-1:0] i_acc);
        logic [SEG_ACC_W-1:0] v_res;
        v_res = '0;
        for (int n = 0; n < SEG_DIGITS; n++) begin
            v_res[4*n +: 4] = bcd_add3(i_acc[4*n +: 4]);
        end
        return v_res;
    endfunction

endpackage

// File: rtl/seg7_enc.sv
// seg7_enc: combinational nibble to 7-segment glyph lookup.
// Output bit0 = segment a ... bit6 = segment g, active-high.
module seg7_enc
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Straight table lookup; the table covers all sixteen nibble values
    always_comb begin
        o_seg = SEG_GLYPHS[i_nib];
    end

endmodule

// File: rtl/bin_to_seg.sv
// bin_to_seg: converts a DW-bit binary value into eight 7-segment glyph
// bytes (d0 = least significant digit). Decimal mode runs a bit-serial
// double-dabble conversion, one input bit per cycle; hex mode maps nibbles
// straight to glyphs. The optional macro BIN_TO_SEG_LZB_EN enables
// leading-zero blanking; without it every digit is displayed.
module bin_to_seg
    import seg_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_hex,
    input  logic [DW-1:0] i_value,
    input  logic [7:0]    i_dp,
    output logic          o_busy,
    output logic          o_done,
    output logic [7:0]    o_d0,
    output logic [7:0]    o_d1,
    output logic [7:0]    o_d2,
    output logic [7:0]    o_d3,
    output logic [7:0]    o_d4,
    output logic [7:0]    o_d5,
    output logic [7:0]    o_d6,
    output logic [7:0]    o_d7
);

    // Bit counter is sized for the widest legal DW (26 -> counts 25..0)
    localparam int CW = 5;

    seg_state_t                       r_state;
    logic [SEG_ACC_W-1:0]             r_acc;
    logic [DW-1:0]                    r_shift;
    logic [CW-1:0]                    r_count;
    logic [7:0]                       r_dp;
    logic                             r_done;
    logic [SEG_DIGITS-1:0][7:0]       r_digits;

    logic [SEG_ACC_W-1:0]             w_accAdj;
    logic [SEG_DIGITS-1:0][6:0]       w_glyph;
    logic [SEG_DIGITS-1:0]            w_blank;
    logic [SEG_DIGITS-1:0][7:0]       w_digit;

    // Add-3 corrected accumulator feeding the next shift step
    always_comb begin
        w_accAdj = bcd_correct(r_acc);
    end

    // One glyph encoder per accumulator nibble
    for (genvar g = 0; g < SEG_DIGITS; g++) begin : g_enc
        seg7_enc u_enc (
            .i_nib (r_acc[4*g +: 4]),
            .o_seg (w_glyph[g])
        );
    end

`ifdef BIN_TO_SEG_LZB_EN
    // Blank zero digits from d7 downward until the first non-zero nibble; d0 always shows
    always_comb begin : p_lzb
        logic v_above;
        w_blank = '0;
        v_above = 1'b1;
        for (int i = SEG_DIGITS - 1; i >= 1; i--) begin
            w_blank[i] = v_above && (r_acc[4*i +: 4] == 4'h0);
            v_above    = w_blank[i];
        end
    end
`else
    // All digits display, leading zeros included
    always_comb begin
        w_blank = '0;
    end
`endif

    // Assemble each output byte: glyph (or dark) plus the latched decimal point
    always_comb begin
        w_digit = '0;
        for (int i = 0; i < SEG_DIGITS; i++) begin
            if (w_blank[i]) begin
                w_digit[i] = SEG_BLANK | {r_dp[i], 7'h00};
            end else begin
                w_digit[i] = {r_dp[i], w_glyph[i]};
            end
        end
    end

    // Conversion FSM: accept in IDLE, shift one bit per cycle, then register all digits at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_shift  <= '0;
            r_count  <= '0;
            r_dp     <= '0;
            r_done   <= 1'b0;
            r_digits <= {SEG_DIGITS{SEG_BLANK}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_dp <= i_dp;
                        if (i_hex) begin
                            r_acc   <= SEG_ACC_W'(i_value);
                            r_state <= ST_ENCODE;
                        end else begin
                            r_acc   <= '0;
                            r_shift <= i_value;
                            r_count <= CW'(DW - 1);
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_acc   <= {w_accAdj[SEG_ACC_W-2:0], r_shift[DW-1]};
                    r_shift <= r_shift << 1;
                    if (r_count == '0) begin
                        r_state <= ST_ENCODE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ST_ENCODE: begin
                    r_digits <= w_digit;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_d0   = r_digits[0];
    assign o_d1   = r_digits[1];
    assign o_d2   = r_digits[2];
    assign o_d3   = r_digits[3];
    assign o_d4   = r_digits[4];
    assign o_d5   = r_digits[5];
    assign o_d6   = r_digits[6];
    assign o_d7   = r_digits[7];

endmodule

// File: tb/tb_bin_to_seg.sv
// tb_bin_to_seg: scoreboard bench for bin_to_seg (DW = 16).
// Stimulus pushes the hand-computed digits and the cycle they are due;
// a monitor pops and compares on every done pulse.
// Expectations follow BIN_TO_SEG_LZB_EN when the bench is built with it.
module tb_bin_to_seg;

    localparam int DW = 16;

`ifdef BIN_TO_SEG_LZB_EN
    localparam logic [7:0] LZ = 8'h00;
`else
    localparam logic [7:0] LZ = 8'h3F;
`endif
    localparam logic [7:0] LZP = LZ | 8'h80;

    localparam logic [63:0] EXP_1234  = {LZ, LZ, LZ, LZ, 8'h06, 8'h5B, 8'h4F, 8'h66};
    localparam logic [63:0] EXP_65535 = {LZ, LZ, LZ, 8'h7D, 8'h6D, 8'h6D, 8'h4F, 8'h6D};
    localparam logic [63:0] EXP_ZERO  = {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 8'h3F};
    localparam logic [63:0] EXP_BEEF  = {LZ, LZ, LZ, LZ, 8'h7C, 8'h79, 8'h79, 8'hF1};
    localparam logic [63:0] EXP_7DP   = {LZP, LZ, LZ, LZ, LZ, LZ, LZ, 8'h87};
    localparam logic [63:0] EXP_H1234 = {LZP, LZP, LZP, LZP, 8'h06, 8'h5B, 8'h4F, 8'h66};
    localparam logic [63:0] EXP_A0C5  = {LZ, LZ, LZ, LZ, 8'h77, 8'h3F, 8'h39, 8'h6D};
    localparam logic [63:0] EXP_10000 = {LZ, LZ, LZ, 8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    localparam logic [63:0] EXP_42    = {LZ, LZ, LZ, LZ, LZ, LZ, 8'h66, 8'h5B};

    typedef struct {
        logic [63:0] digits;
        int          dueCycle;
        string       tag;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          hexSel;
    logic [DW-1:0] valueIn;
    logic [7:0]    dpIn;
    logic          busy;
    logic          done;
    logic [7:0]    d0, d1, d2, d3, d4, d5, d6, d7;
    logic [63:0]   dutDigits;

    int   cyc        = 0;
    int   checkCount = 0;
    int   errCount   = 0;
    int   doneCount  = 0;
    exp_t sbQ[$];

    assign dutDigits = {d7, d6, d5, d4, d3, d2, d1, d0};

    bin_to_seg #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start),
        .i_hex   (hexSel),
        .i_value (valueIn),
        .i_dp    (dpIn),
        .o_busy  (busy),
        .o_done  (done),
        .o_d0    (d0),
        .o_d1    (d1),
        .o_d2    (d2),
        .o_d3    (d3),
        .o_d4    (d4),
        .o_d5    (d5),
        .o_d6    (d6),
        .o_d7    (d7)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running edge counter used to time-stamp expected results
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Compare one value and report it when it differs
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            doneCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected done", 64'd1, 64'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput({e.tag, " digits"}, dutDigits, e.digits);
                checkOutput({e.tag, " cycle"}, 64'(cyc), 64'(e.dueCycle));
            end
        end
    end

    // Issue one conversion, queue its expectation, wait for busy to drop and check its width
    task automatic applyStimulus(input logic hexMode, input logic [DW-1:0] val, input logic [7:0] dpMask,
                                 input logic [63:0] expDigits, input string tag);
        exp_t e;
        int   lat;
        int   busyCycles;
        lat = hexMode ? 1 : DW + 1;
        @(negedge clk);
        start   = 1'b1;
        hexSel  = hexMode;
        valueIn = val;
        dpIn    = dpMask;
        e.digits   = expDigits;
        e.dueCycle = cyc + 1 + lat;
        e.tag      = tag;
        sbQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
        busyCycles = 0;
        while (busy && busyCycles < 100) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'(lat));
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   doneBefore;
        int   n;

        rst_n   = 1'b0;
        start   = 1'b0;
        hexSel  = 1'b0;
        valueIn = '0;
        dpIn    = '0;

        #1;
        checkOutput("reset digits", dutDigits, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 16'd1234, 8'h00, EXP_1234, "dec1234");
        repeat (5) @(negedge clk);
        checkOutput("hold digits", dutDigits, EXP_1234);

        applyStimulus(1'b0, 16'd65535, 8'h00, EXP_65535, "dec65535");
        applyStimulus(1'b0, 16'd0,     8'h00, EXP_ZERO,  "dec0");
        applyStimulus(1'b1, 16'hBEEF,  8'h01, EXP_BEEF,  "hexBEEF");
        applyStimulus(1'b0, 16'd7,     8'h81, EXP_7DP,   "dec7dp");
        applyStimulus(1'b1, 16'h1234,  8'hF0, EXP_H1234, "hex1234dp");
        applyStimulus(1'b1, 16'hA0C5,  8'h00, EXP_A0C5,  "hexA0C5");

        // A second start five cycles into a conversion must be ignored
        @(negedge clk);
        start   = 1'b1;
        hexSel  = 1'b0;
        valueIn = 16'd1234;
        dpIn    = 8'h00;
        e.digits   = EXP_1234;
        e.dueCycle = cyc + 1 + DW + 1;
        e.tag      = "ignore";
        sbQ.push_back(e);
        doneBefore = doneCount;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start   = 1'b1;
        hexSel  = 1'b1;
        valueIn = 16'd999;
        dpIn    = 8'hFF;
        @(negedge clk);
        start   = 1'b0;
        hexSel  = 1'b0;
        dpIn    = 8'h00;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("ignore done count", 64'(doneCount - doneBefore), 64'd1);

        // Start held high: back-to-back conversions, one every DW+2 cycles
        @(negedge clk);
        start   = 1'b1;
        hexSel  = 1'b0;
        valueIn = 16'd42;
        dpIn    = 8'h00;
        for (int k = 0; k < 3; k++) begin
            e.digits   = EXP_42;
            e.dueCycle = cyc + 1 + (DW + 2) * k + DW + 1;
            e.tag      = "b2b42";
            sbQ.push_back(e);
        end
        repeat (37) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        checkOutput("b2b drained", 64'(sbQ.size()), 64'd0);

        // Reset eight cycles into a conversion blanks everything at once, no done
        @(negedge clk);
        start   = 1'b1;
        hexSel  = 1'b0;
        valueIn = 16'd65535;
        @(negedge clk);
        start = 1'b0;
        doneBefore = doneCount;
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort digits", dutDigits, 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        checkOutput("abort no done", 64'(doneCount - doneBefore), 64'd0);

        applyStimulus(1'b0, 16'd10000, 8'h00, EXP_10000, "dec10000");
        repeat (3) @(negedge clk);
        checkOutput("scoreboard empty", 64'(sbQ.size()), 64'd0);

        $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
